port_input_cond: RTL and testbench

Input conditioning stage for one 8-bit GPIO port, placed between the pad inputs and the port function block's `y_portX_i` input. For every pin it:
- synchronises the pad value into the core clock domain;
- optionally debounces it;
- detects the selected edge and latches a per-pin interrupt flag;
- drives a single registered port interrupt request to the interrupt controller.

One instance is used per interrupt-capable port (P0–P3).

---
 rtl/port_input_cond_pkg.sv | 12 +
 rtl/port_input_cond_if.sv | 23 ++
 rtl/port_input_cond_bit_filter.sv | 65 ++++++
 rtl/port_input_cond.sv | 56 +++++
 tb/tb_port_input_cond.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/port_input_cond_pkg.sv
// Shared constants for the GPIO port input conditioning stage.
// Build option: PORT_DEBOUNCE_EN compiles in the per-pin debounce counters.
package port_pkg;

    localparam int   PORT_WIDTH      = 8;
    localparam int   DEB_LEN_DEFAULT = 8;

    // Edge-select encodings for sfr_PXIES_i
    localparam logic ES_RISE = 1'b0;
    localparam logic ES_FALL = 1'b1;

endpackage

// File: rtl/port_input_cond_if.sv
// Pad / SFR side of the port input conditioner.
// The master drives pad values and SFR controls; the slave returns conditioned values, flags and the request.
interface port_input_cond_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] y_port_i;
    logic [WIDTH-1:0] sfr_PXIE_i;
    logic [WIDTH-1:0] sfr_PXIES_i;
    logic [WIDTH-1:0] sfr_PXIFG_clr_i;
    logic [WIDTH-1:0] port_sync_o;
    logic [WIDTH-1:0] port_ifg_o;
    logic             port_irq_o;

    modport master (
        output y_port_i, sfr_PXIE_i, sfr_PXIES_i, sfr_PXIFG_clr_i,
        input  port_sync_o, port_ifg_o, port_irq_o
    );

    modport slave (
        input  y_port_i, sfr_PXIE_i, sfr_PXIES_i, sfr_PXIFG_clr_i,
        output port_sync_o, port_ifg_o, port_irq_o
    );
endinterface

// File: rtl/port_input_cond_bit_filter.sv
// One pin: two-flop synchroniser, optional debounce counter and stable register.
// Build option: PORT_DEBOUNCE_EN enables the counter; otherwise stable follows s2 every cycle.
module port_bit_filter #(
    parameter int DEB_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pad_i,
    output logic stable_o,
    output logic update_o
);
    logic s1_q;
    logic s2_q;
    logic stable_q;
    logic diff;

    assign diff = s2_q ^ stable_q;

`ifdef PORT_DEBOUNCE_EN
    localparam int             CW      = $clog2(DEB_LEN);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_LEN - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Acceptance happens on the DEB_LEN-th consecutive differing cycle
    assign update_o = diff & (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (!diff || update_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign update_o = diff;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            s1_q <= pad_i;
            s2_q <= s1_q;
            if (update_o) begin
                stable_q <= s2_q;
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/port_input_cond.sv
// GPIO port input conditioning: per-pin filtering, edge flags and a registered port interrupt request.
// Build option: PORT_DEBOUNCE_EN selects debounced filtering inside port_bit_filter.
module port_input_cond
    import port_pkg::*;
#(
    parameter int WIDTH   = PORT_WIDTH,
    parameter int DEB_LEN = DEB_LEN_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    port_input_cond_if.slave  bus
);
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] ifg_q;
    logic [WIDTH-1:0] ifg_d;
    logic             irq_q;
    logic             irq_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        port_bit_filter #(
            .DEB_LEN (DEB_LEN)
        ) u_filter (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .pad_i    (bus.y_port_i[i]),
            .stable_o (stable[i]),
            .update_o (update[i])
        );

        // On an update the new value is the complement of the current stable value
        assign set[i] = (bus.sfr_PXIES_i[i] == ES_FALL) ? (update[i] &  stable[i])
                                                         : (update[i] & ~stable[i]);
    end

    always_comb begin
        ifg_d = (ifg_q & ~bus.sfr_PXIFG_clr_i) | set;
        irq_d = |(ifg_q & bus.sfr_PXIE_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ifg_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ifg_q <= ifg_d;
            irq_q <= irq_d;
        end
    end

    assign bus.port_sync_o = stable;
    assign bus.port_ifg_o  = ifg_q;
    assign bus.port_irq_o  = irq_q;

endmodule

// File: tb/tb_port_input_cond.sv
// Self-checking bench for port_input_cond: directed scenarios plus randomized pad/SFR traffic
// compared every cycle against a window-based behavioural model.
module tb_port_input_cond;

`ifdef PORT_DEBOUNCE_EN
    localparam int DL = 8;
`else
    localparam int DL = 1;
`endif
    localparam int LAT = 2 + DL;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    port_input_cond_if #(.WIDTH(8)) bus ();

    port_input_cond dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: pad samples history; a pin is accepted when the last DL filter-visible
    // samples (pad taken two edges earlier) all differ from the stable value.
    logic [7:0] hist [0:DL+1];
    logic [7:0] m_stable, m_ifg;
    logic       m_irq;
    logic [7:0] m_acc, m_new, m_set;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= DL + 1; i++) hist[i] = 8'h00;
            m_stable = 8'h00;
            m_ifg    = 8'h00;
            m_irq    = 1'b0;
        end else begin
            for (int i = DL + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = bus.y_port_i;
            m_acc = 8'hFF;
            for (int j = 0; j < DL; j++) m_acc = m_acc & (hist[2+j] ^ m_stable);
            m_new = m_stable ^ m_acc;
            m_set = m_acc & ((~bus.sfr_PXIES_i & m_new) | (bus.sfr_PXIES_i & ~m_new));
            m_irq = |(m_ifg & bus.sfr_PXIE_i);
            m_ifg = (m_ifg & ~bus.sfr_PXIFG_clr_i) | m_set;
            m_stable = m_new;
        end
    end

    always @(negedge clk) begin
        chk("model_sync", bus.port_sync_o, m_stable);
        chk("model_ifg",  bus.port_ifg_o,  m_ifg);
        chk("model_irq",  bus.port_irq_o,  m_irq);
    end

    task automatic clear_flags(input logic [7:0] mask);
        bus.sfr_PXIFG_clr_i = mask;
        @(negedge clk);
        bus.sfr_PXIFG_clr_i = 8'h00;
    endtask

    initial begin
        bus.y_port_i        = 8'hFF;
        bus.sfr_PXIE_i      = 8'h00;
        bus.sfr_PXIES_i     = 8'h00;
        bus.sfr_PXIFG_clr_i = 8'h00;

        // Reset held with pads high
        repeat (3) @(negedge clk);
        chk("rst_sync", bus.port_sync_o, 8'h00);
        chk("rst_ifg",  bus.port_ifg_o,  8'h00);
        chk("rst_irq",  bus.port_irq_o,  1'b0);
        rst_n = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        chk("startup_ifg_early", bus.port_ifg_o, 8'h00);
        @(negedge clk);
        chk("startup_ifg",  bus.port_ifg_o,  8'hFF);
        chk("startup_sync", bus.port_sync_o, 8'hFF);
        repeat (3) @(negedge clk);
        chk("startup_irq", bus.port_irq_o, 1'b0);

        bus.y_port_i = 8'h00;
        repeat (LAT + 2) @(negedge clk);
        clear_flags(8'hFF);
        chk("cleared_all", bus.port_ifg_o, 8'h00);

        // Rising edge on bit 3
        bus.sfr_PXIE_i = 8'h08;
        bus.y_port_i   = 8'h08;
        repeat (LAT - 1) @(negedge clk);
        chk("rise3_sync_early", bus.port_sync_o[3], 1'b0);
        @(negedge clk);
        chk("rise3_sync", bus.port_sync_o[3], 1'b1);
        chk("rise3_ifg",  bus.port_ifg_o[3],  1'b1);
        chk("rise3_irq_early", bus.port_irq_o, 1'b0);
        @(negedge clk);
        chk("rise3_irq", bus.port_irq_o, 1'b1);
        bus.sfr_PXIE_i = 8'h00;
        clear_flags(8'hFF);

        // Glitch on bit 0
        bus.y_port_i = 8'h09;
        repeat (5) @(negedge clk);
        bus.y_port_i = 8'h08;
        repeat (LAT + 2) @(negedge clk);
`ifdef PORT_DEBOUNCE_EN
        chk("glitch_sync", bus.port_sync_o[0], 1'b0);
        chk("glitch_ifg",  bus.port_ifg_o[0],  1'b0);
`endif
        clear_flags(8'hFF);
        bus.y_port_i = 8'h09;
        repeat (8) @(negedge clk);
        bus.y_port_i = 8'h08;
        repeat (LAT + 2) @(negedge clk);
        chk("pulse8_ifg", bus.port_ifg_o[0], 1'b1);

        // Falling select on bit 7
        clear_flags(8'hFF);
        bus.sfr_PXIES_i = 8'h80;
        bus.y_port_i    = 8'h88;
        repeat (LAT + 2) @(negedge clk);
        chk("fall7_on_rise", bus.port_ifg_o[7], 1'b0);
        bus.y_port_i = 8'h08;
        repeat (LAT) @(negedge clk);
        chk("fall7_ifg", bus.port_ifg_o[7], 1'b1);
        clear_flags(8'hFF);
        bus.sfr_PXIES_i = 8'hFF;
        repeat (3) @(negedge clk);
        bus.sfr_PXIES_i = 8'h00;
        repeat (3) @(negedge clk);
        chk("ies_change_no_flag", bus.port_ifg_o, 8'h00);

        // Set and clear together on bit 2
        bus.sfr_PXIE_i = 8'h04;
        bus.y_port_i   = 8'h0C;
        repeat (LAT - 1) @(negedge clk);
        bus.sfr_PXIFG_clr_i = 8'h04;
        @(negedge clk);
        chk("set_wins_ifg", bus.port_ifg_o[2], 1'b1);
        @(negedge clk);
        bus.sfr_PXIFG_clr_i = 8'h00;
        chk("late_clr_ifg", bus.port_ifg_o[2], 1'b0);
        chk("late_clr_irq_still", bus.port_irq_o, 1'b1);
        @(negedge clk);
        chk("late_clr_irq", bus.port_irq_o, 1'b0);

        // Late enable on bit 5
        bus.sfr_PXIE_i = 8'h00;
        bus.y_port_i   = 8'h2C;
        repeat (LAT + 1) @(negedge clk);
        chk("late_en_ifg", bus.port_ifg_o[5], 1'b1);
        chk("late_en_irq_off", bus.port_irq_o, 1'b0);
        bus.sfr_PXIE_i = 8'h20;
        @(negedge clk);
        chk("late_en_irq", bus.port_irq_o, 1'b1);

        // Randomized traffic, with one reset in the middle
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0)
                bus.y_port_i = bus.y_port_i ^ 8'($urandom_range(0, 255));
            bus.sfr_PXIFG_clr_i = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            if ($urandom_range(0, 19) == 0) bus.sfr_PXIE_i  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) bus.sfr_PXIES_i = 8'($urandom_range(0, 255));
            if (c == 700) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
